// File: rtl/tuner_ddc.sv
// Digital down-converter tuner: phase-continuous NCO, sine ROM, complex mixer with rounding/saturation.
// Optional phase dither LFSR enabled by defining TUNER_DDC_DITHER_EN.
module tuner_ddc #(
  parameter int DSZ = 16,
  parameter int FSZ = 26,
  parameter int PSZ = 12,
  parameter int CSZ = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic signed [DSZ-1:0] in,
  input  logic                  in_valid,
  input  logic        [FSZ-1:0] cfg_freq,
  input  logic        [PSZ-1:0] cfg_phase,
  input  logic                  cfg_load,
  output logic                  cfg_ack,
  input  logic                  phase_sync,
  input  logic                  lo_ns_en,
  input  logic                  iq_swap,
  output logic signed [DSZ-1:0] out_i,
  output logic signed [DSZ-1:0] out_q,
  output logic                  out_valid,
  output logic                  sat
);

  localparam int RSZ   = FSZ - PSZ;
  localparam int PW    = DSZ + CSZ;
  localparam int DEPTH = 1 << PSZ;
  localparam logic [PSZ-1:0]        QTR      = PSZ'(1) << (PSZ - 2);
  localparam logic signed [PW:0]    RND_HALF = (PW + 1)'(1) << (CSZ - 2);
  localparam logic signed [PW:0]    SAT_MAX  = (PW + 1)'((1 << (DSZ - 1)) - 1);
  localparam logic signed [PW:0]    SAT_MIN  = ~SAT_MAX;
  localparam real                   PI       = 3.14159265358979323846;

  function automatic logic signed [CSZ-1:0] sin_entry(input int k);
    real v;
    v = (2.0 ** (CSZ - 1) - 1.0) * $sin(2.0 * PI * k / (2.0 ** PSZ));
    return CSZ'((v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v));
  endfunction

  // Returns {clipped, value}
  function automatic logic [DSZ:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW:0] r;
    r = $signed({p[PW-1], p}) + RND_HALF;
    r = r >>> (CSZ - 1);
    if (r > SAT_MAX) return {1'b1, SAT_MAX[DSZ-1:0]};
    if (r < SAT_MIN) return {1'b1, SAT_MIN[DSZ-1:0]};
    return {1'b0, r[DSZ-1:0]};
  endfunction

  logic signed [CSZ-1:0] sin_rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign sin_rom[k] = sin_entry(k);
  end

  logic [FSZ-1:0] freq_sh_q, freq_sh_d, freq_act_q, freq_act_d;
  logic [PSZ-1:0] phase_sh_q, phase_sh_d, phase_act_q, phase_act_d;
  logic           cfg_pend_q, cfg_pend_d, sync_pend_q, sync_pend_d;
  logic [FSZ-1:0] acc_q, acc_d;
  logic [RSZ-1:0] res_q, res_d;

  logic                  s1_valid_q, s1_valid_d;
  logic signed [DSZ-1:0] s1_in_q, s1_in_d;
  logic        [PSZ-1:0] s1_phs_q, s1_phs_d;
  logic                  s2_valid_q, s2_valid_d;
  logic signed [DSZ-1:0] s2_in_q, s2_in_d;
  logic signed [CSZ-1:0] s2_sin_q, s2_sin_d, s2_cos_q, s2_cos_d;
  logic                  s3_valid_q, s3_valid_d;
  logic signed [PW-1:0]  s3_pi_q, s3_pi_d, s3_pq_q, s3_pq_d;
  logic signed [DSZ-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic                  out_valid_q, out_valid_d, sat_q, sat_d;

  logic           apply_cfg, sync_now;
  logic [FSZ-1:0] freq_eff, acc_cur, ns_add, ns_acc, dither;
  logic [PSZ-1:0] phase_eff, phs, cos_addr;
  logic [RSZ-1:0] res_cur;
  logic signed [PW-1:0] in_ext, sin_ext, cos_ext;
  logic [DSZ:0]   rs_i, rs_q;

`ifdef TUNER_DDC_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (in_valid) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end

  assign dither = FSZ'(lfsr_q[RSZ-2:0]);
`else
  assign dither = '0;
`endif

  assign cfg_ack = apply_cfg;

  // Pending config and sync are consumed by the first accepted sample; that sample already uses them.
  always_comb begin
    apply_cfg = in_valid & cfg_pend_q;
    sync_now  = in_valid & (sync_pend_q | phase_sync);
    freq_eff  = apply_cfg ? freq_sh_q : freq_act_q;
    phase_eff = apply_cfg ? phase_sh_q : phase_act_q;
    acc_cur   = sync_now ? '0 : acc_q;
    res_cur   = sync_now ? '0 : res_q;
    ns_add    = lo_ns_en ? {{PSZ{res_cur[RSZ-1]}}, res_cur} : dither;
    ns_acc    = acc_cur + ns_add;
    phs       = ns_acc[FSZ-1:RSZ] + phase_eff;

    freq_sh_d   = cfg_load ? cfg_freq : freq_sh_q;
    phase_sh_d  = cfg_load ? cfg_phase : phase_sh_q;
    cfg_pend_d  = cfg_load | (cfg_pend_q & ~in_valid);
    sync_pend_d = (sync_pend_q | phase_sync) & ~in_valid;
    freq_act_d  = freq_act_q;
    phase_act_d = phase_act_q;
    acc_d       = acc_q;
    res_d       = res_q;
    if (in_valid) begin
      freq_act_d  = freq_eff;
      phase_act_d = phase_eff;
      acc_d       = acc_cur + freq_eff;
      res_d       = sync_now ? '0 : ns_acc[RSZ-1:0];
    end

    s1_valid_d = in_valid;
    s1_in_d    = in;
    s1_phs_d   = phs;
  end

  always_comb begin
    cos_addr   = s1_phs_q + QTR;
    s2_valid_d = s1_valid_q;
    s2_in_d    = s1_in_q;
    s2_sin_d   = sin_rom[s1_phs_q];
    s2_cos_d   = sin_rom[cos_addr];

    in_ext     = {{CSZ{s2_in_q[DSZ-1]}}, s2_in_q};
    sin_ext    = {{DSZ{s2_sin_q[CSZ-1]}}, s2_sin_q};
    cos_ext    = {{DSZ{s2_cos_q[CSZ-1]}}, s2_cos_q};
    s3_valid_d = s2_valid_q;
    s3_pi_d    = in_ext * cos_ext;
    s3_pq_d    = -(in_ext * sin_ext);

    rs_i        = round_sat(s3_pi_q);
    rs_q        = round_sat(s3_pq_q);
    out_valid_d = s3_valid_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    sat_d       = 1'b0;
    if (s3_valid_q) begin
      out_i_d = iq_swap ? rs_q[DSZ-1:0] : rs_i[DSZ-1:0];
      out_q_d = iq_swap ? rs_i[DSZ-1:0] : rs_q[DSZ-1:0];
      sat_d   = rs_i[DSZ] | rs_q[DSZ];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freq_sh_q   <= '0;
      phase_sh_q  <= '0;
      freq_act_q  <= '0;
      phase_act_q <= '0;
      cfg_pend_q  <= 1'b0;
      sync_pend_q <= 1'b0;
      acc_q       <= '0;
      res_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_in_q     <= '0;
      s1_phs_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_in_q     <= '0;
      s2_sin_q    <= '0;
      s2_cos_q    <= '0;
      s3_valid_q  <= 1'b0;
      s3_pi_q     <= '0;
      s3_pq_q     <= '0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      freq_sh_q   <= freq_sh_d;
      phase_sh_q  <= phase_sh_d;
      freq_act_q  <= freq_act_d;
      phase_act_q <= phase_act_d;
      cfg_pend_q  <= cfg_pend_d;
      sync_pend_q <= sync_pend_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      s1_valid_q  <= s1_valid_d;
      s1_in_q     <= s1_in_d;
      s1_phs_q    <= s1_phs_d;
      s2_valid_q  <= s2_valid_d;
      s2_in_q     <= s2_in_d;
      s2_sin_q    <= s2_sin_d;
      s2_cos_q    <= s2_cos_d;
      s3_valid_q  <= s3_valid_d;
      s3_pi_q     <= s3_pi_d;
      s3_pq_q     <= s3_pq_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign out_i     = out_i_q;
  assign out_q     = out_q_q;
  assign out_valid = out_valid_q;
  assign sat       = sat_q;

endmodule
